// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 8-bit ALU among NREQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU sampled) -> RESP (held until taken).
module alu_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [8*NREQ-1:0]       req_a,
    input  logic [8*NREQ-1:0]       req_b,
    output logic [1:0]              alu_op,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    input  logic [7:0]              alu_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [7:0]              rsp_data,
    output logic                    rsp_err
);

    localparam int unsigned ID_W   = $clog2(NREQ);
    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 8;
    localparam logic [OP_W-1:0] OP_MOD = OP_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;

    logic [NREQ-1:0]     w_grant;
    logic [ID_W-1:0]     w_win;
    logic                w_found;
    logic [ID_W:0]       w_sum;
    logic [ID_W-1:0]     w_idx;
    logic [OP_W-1:0]     w_sel_op;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic                w_take;
    logic                w_err;
    logic [ID_W-1:0]     w_ptr_nxt;

    // First valid requester searching upward from rr_ptr, wrapping at NREQ
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            w_idx = (w_sum >= (ID_W+1)'(NREQ)) ? ID_W'(w_sum - (ID_W+1)'(NREQ)) : ID_W'(w_sum);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_grant[w_win] = w_found;
    end

    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op = req_op[i*OP_W +: OP_W];
                w_sel_a  = req_a[i*DATA_W +: DATA_W];
                w_sel_b  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = (r_state == IDLE && !reset) ? w_grant : '0;
    assign w_take    = |(req_ready & req_valid);
    assign w_err     = (r_op == OP_MOD) && (r_b == '0);
    assign w_ptr_nxt = (w_win == ID_W'(NREQ-1)) ? '0 : w_win + ID_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_take) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch on grant; response capture at the end of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_take) begin
                r_op     <= w_sel_op;
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_id     <= w_win;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_err   <= w_err;
                r_rsp_data  <= w_err ? '0 : alu_out;
            end else if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level round-robin / ALU reference model.
module tb_alu_arbiter;
    localparam int unsigned NREQ = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_op;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [1:0]          alu_op;
    logic [7:0]          alu_a;
    logic [7:0]          alu_b;
    logic [7:0]          alu_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [7:0]          rsp_data;
    logic                rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cycle  = 0;
    int m_ptr  = 0;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia = int'(a);
        int ib = int'(b);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return (ib >= 8) ? 8'h00 : 8'((ia * (1 << ib)) % 256);
            2'd2:    return (ib == 0) ? 8'h00 : 8'(ia % ib);
            default: return 8'(255 - (ia & ib));
        endcase
    endfunction

    // Shared ALU stub; MOD by zero returns junk that the arbiter must suppress
    assign alu_out = (alu_op == 2'd2 && alu_b == 8'd0) ? 8'hA5 : ref_alu(alu_op, alu_a, alu_b);

    function automatic int rr_pick(input logic [3:0] pend, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]       = v;
        req_op[2*i +: 2]   = op;
        req_a[8*i +: 8]    = a;
        req_b[8*i +: 8]    = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic run_one(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ed, input logic ee, input string nm);
        int w = 0;
        req_valid = '0;
        set_req(id, 1'b1, op, a, b);
        #1;
        while (req_ready !== 4'(1 << id) && w < 10) begin
            step();
            w++;
        end
        chk({nm, "_grant"}, int'(req_ready), 1 << id);
        step();
        m_ptr = (id + 1) % 4;
        req_valid[id] = 1'b0;
        chk({nm, "_exec_nvalid"}, int'(rsp_valid), 0);
        chk({nm, "_alu_a"}, int'(alu_a), int'(a));
        step();
        chk({nm, "_valid"}, int'(rsp_valid), 1);
        chk({nm, "_id"}, int'(rsp_id), id);
        chk({nm, "_data"}, int'(rsp_data), int'(ed));
        chk({nm, "_err"}, int'(rsp_err), int'(ee));
        step();
        chk({nm, "_done"}, int'(rsp_valid), 0);
    endtask

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       e;
        string      nm;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pend;
        logic [1:0] p_op [4];
        logic [7:0] p_a  [4];
        logic [7:0] p_b  [4];
        logic [7:0] hold;
        int         w, last, bp;

        vecs[0] = '{1, 2'd0, 8'hF0, 8'h3C, 8'hCC, 1'b0, "xor"};
        vecs[1] = '{0, 2'd2, 8'd7,  8'd0,  8'h00, 1'b1, "mod0"};
        vecs[2] = '{2, 2'd2, 8'd7,  8'd3,  8'd1,  1'b0, "mod3"};
        vecs[3] = '{3, 2'd1, 8'h81, 8'd1,  8'h02, 1'b0, "shl1"};
        vecs[4] = '{1, 2'd1, 8'h81, 8'd9,  8'h00, 1'b0, "shl9"};
        vecs[5] = '{2, 2'd3, 8'hFF, 8'hFF, 8'h00, 1'b0, "nandff"};
        vecs[6] = '{0, 2'd1, 8'h01, 8'd7,  8'h80, 1'b0, "shl7"};
        vecs[7] = '{3, 2'd3, 8'h0F, 8'hF0, 8'hFF, 1'b0, "nand"};

        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2;
        req_valid = 4'hF;
        step();
        step();
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_alu", int'({alu_op, alu_a, alu_b}), 0);
        req_valid = '0;
        reset     = 1'b0;
        m_ptr     = 0;
        #1;
        chk("idle_no_req", int'(req_ready), 0);
        step();

        for (int v = 0; v < 8; v++)
            run_one(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].e, vecs[v].nm);

        // All requesters continuously valid: round-robin order, one grant per 3 cycles
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 8'(8'h10 + i), 8'(i + 1));
        #1;
        last = 0;
        for (int g = 0; g < 8; g++) begin
            w = rr_pick(4'hF, m_ptr);
            chk("rr_order", w, g % 4);
            chk("rr_grant", int'(req_ready), 1 << w);
            if (g > 0) chk("rr_spacing", cycle - last, 3);
            last = cycle;
            step();
            m_ptr = (w + 1) % 4;
            step();
            chk("rr_id", int'(rsp_id), w);
            chk("rr_data", int'(rsp_data), int'(ref_alu(2'(w), 8'(8'h10 + w), 8'(w + 1))));
            step();
        end

        // Backpressure with requester 2 waiting
        req_valid = '0;
        set_req(1, 1'b1, 2'd0, 8'h55, 8'h0F);
        #1;
        chk("bp_grant1", int'(req_ready), 1 << rr_pick(4'b0010, m_ptr));
        step();
        m_ptr = 2;
        req_valid[1] = 1'b0;
        set_req(2, 1'b1, 2'd3, 8'hF0, 8'h3C);
        rsp_ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_data", int'(rsp_data), 8'h5A);
            chk("bp_id", int'(rsp_id), 1);
            chk("bp_ready_zero", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_released", int'(rsp_valid), 0);
        chk("bp_grant2", int'(req_ready), 4'b0100);
        step();
        m_ptr = 3;
        req_valid[2] = 1'b0;
        step();
        chk("bp_data2", int'(rsp_data), 8'hCF);
        chk("bp_id2", int'(rsp_id), 2);
        step();

        // Reset during EXEC discards the operation
        req_valid = '0;
        set_req(2, 1'b1, 2'd0, 8'h01, 8'h02);
        #1;
        chk("rx_grant", int'(req_ready), 4'b0100);
        step();
        req_valid[2] = 1'b0;
        set_req(3, 1'b1, 2'd0, 8'h11, 8'h22);
        reset = 1'b1;
        #1;
        chk("rx_rsp_valid", int'(rsp_valid), 0);
        chk("rx_ready", int'(req_ready), 0);
        step();
        reset     = 1'b0;
        m_ptr     = 0;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rx_no_stale", int'(rsp_valid), 0);
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd0, 8'(i), 8'h40);
        #1;
        chk("rx_ptr0", int'(req_ready), 4'b0001);
        step();
        m_ptr = 1;
        req_valid = '0;
        step();
        chk("rx_id", int'(rsp_id), 0);
        chk("rx_data", int'(rsp_data), 8'h40);
        step();

        // Randomized traffic with random backpressure
        pend = '0;
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    p_op[i] = 2'($urandom_range(0, 3));
                    p_a[i]  = 8'($urandom);
                    p_b[i]  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
                    set_req(i, 1'b1, p_op[i], p_a[i], p_b[i]);
                end
            end
            #1;
            if (pend == '0) begin
                chk("rnd_idle", int'(req_ready), 0);
                step();
                continue;
            end
            w = rr_pick(pend, m_ptr);
            chk("rnd_grant", int'(req_ready), 1 << w);
            step();
            pend[w]      = 1'b0;
            req_valid[w] = 1'b0;
            m_ptr        = (w + 1) % 4;
            step();
            chk("rnd_valid", int'(rsp_valid), 1);
            chk("rnd_id", int'(rsp_id), w);
            chk("rnd_err", int'(rsp_err), int'(p_op[w] == 2'd2 && p_b[w] == 8'd0));
            chk("rnd_data", int'(rsp_data), int'(ref_alu(p_op[w], p_a[w], p_b[w])));
            hold = rsp_data;
            bp   = $urandom_range(0, 3);
            for (int k = 0; k < bp; k++) begin
                rsp_ready = 1'b0;
                step();
                chk("rnd_hold_valid", int'(rsp_valid), 1);
                chk("rnd_hold_data", int'(rsp_data), int'(hold));
                chk("rnd_hold_ready", int'(req_ready), 0);
            end
            rsp_ready = 1'b1;
            step();
            chk("rnd_done", int'(rsp_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
